inst_fetch: RTL and testbench

Instruction fetch stage for the single-issue MIPS pipeline. Holds the program counter, drives the word address into the combinational instruction memory, and captures the returned word into the IF/ID pipeline register. Sequential behaviour covers sequential PC advance, stalls, branch/jump redirect and IF/ID flush. It sits between hazard/branch control and the decode stage.

---
 rtl/mips_pkg.sv | 20 ++
 rtl/if_id_reg.sv | 25 ++
 rtl/inst_fetch.sv | 77 +++++++
 tb/tb_inst_fetch.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared constants and payload types for the MIPS pipeline stages.
package mips_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [XLEN-1:0] NOP_INST         = 32'h0000_0000;
  localparam logic [XLEN-1:0] PC_INC           = 32'd4;
  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

  // IF/ID payload: captured instruction and the PC+4 that goes with it
  typedef struct packed {
    logic [XLEN-1:0] inst;
    logic [XLEN-1:0] pc4;
  } if_id_t;

  function automatic logic [XLEN-1:0] align_word(input logic [XLEN-1:0] addr);
    return {addr[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: reset/flush clear to NOP, stall holds, otherwise load.
module if_id_reg
  import mips_pkg::*;
(
  input  logic   clk,
  input  logic   reset,
  input  logic   stall,
  input  logic   flush,
  input  if_id_t d,
  output if_id_t q,
  output logic   valid
);

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      q.inst <= NOP_INST;
      q.pc4  <= '0;
      valid  <= 1'b0;
    end else if (!stall) begin
      q      <= d;
      valid  <= 1'b1;
    end
  end

endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch stage: PC register, redirect handling and IF/ID capture.
module inst_fetch
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        flush,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic [31:0] im_addr,
  input  logic [31:0] im_data,
  output logic [31:0] pc,
  output logic [31:0] if_inst,
  output logic [31:0] if_pc4,
  output logic        if_valid,
  output logic        addr_err,
  output logic [31:0] fetch_cnt
);

  logic [XLEN-1:0] pc_plus4;
  logic            load;
  logic            misaligned;
  if_id_t          if_d;
  if_id_t          if_q;

  assign pc_plus4   = pc + PC_INC;
  assign load       = !reset && !flush && !stall;
  assign misaligned = branch_taken && (branch_target[1:0] != 2'b00);
  assign im_addr    = pc;

  // Redirect beats stall so a branch resolved during a hazard is not lost
  always_ff @(posedge clk) begin
    if (reset) begin
      pc <= RESET_PC;
    end else if (branch_taken) begin
      pc <= align_word(branch_target);
    end else if (!stall) begin
      pc <= pc_plus4;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      addr_err <= 1'b0;
    end else if (misaligned) begin
      addr_err <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_cnt <= '0;
    end else if (load) begin
      fetch_cnt <= fetch_cnt + 32'd1;
    end
  end

  assign if_d.inst = im_data;
  assign if_d.pc4  = pc_plus4;

  if_id_reg u_if_id (
    .clk   (clk),
    .reset (reset),
    .stall (stall),
    .flush (flush),
    .d     (if_d),
    .q     (if_q),
    .valid (if_valid)
  );

  assign if_inst = if_q.inst;
  assign if_pc4  = if_q.pc4;

endmodule

// File: tb/tb_inst_fetch.sv
// Directed bench for inst_fetch with a combinational instruction memory model.
module tb_inst_fetch;

  logic        clk;
  logic        reset;
  logic        stall;
  logic        flush;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic [31:0] im_addr;
  logic [31:0] im_data;
  logic [31:0] pc;
  logic [31:0] if_inst;
  logic [31:0] if_pc4;
  logic        if_valid;
  logic        addr_err;
  logic [31:0] fetch_cnt;

  logic [31:0] w_im_addr;
  logic [31:0] w_im_data;
  logic [31:0] w_pc;
  logic [31:0] w_if_inst;
  logic [31:0] w_if_pc4;
  logic        w_if_valid;
  logic        w_addr_err;
  logic [31:0] w_fetch_cnt;
  logic        zero1;
  logic [31:0] zero32;

  logic [31:0] mem [0:127];

  int checks = 0;
  int errors = 0;

  assign im_data   = mem[im_addr[8:2]];
  assign w_im_data = mem[w_im_addr[8:2]];
  assign zero1     = 1'b0;
  assign zero32    = 32'h0;

  inst_fetch dut (
    .clk           (clk),
    .reset         (reset),
    .stall         (stall),
    .flush         (flush),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .im_addr       (im_addr),
    .im_data       (im_data),
    .pc            (pc),
    .if_inst       (if_inst),
    .if_pc4        (if_pc4),
    .if_valid      (if_valid),
    .addr_err      (addr_err),
    .fetch_cnt     (fetch_cnt)
  );

  inst_fetch #(.RESET_PC(32'hFFFF_FFFC)) dut_w (
    .clk           (clk),
    .reset         (reset),
    .stall         (zero1),
    .flush         (zero1),
    .branch_taken  (zero1),
    .branch_target (zero32),
    .im_addr       (w_im_addr),
    .im_data       (w_im_data),
    .pc            (w_pc),
    .if_inst       (w_if_inst),
    .if_pc4        (w_if_pc4),
    .if_valid      (w_if_valid),
    .addr_err      (w_addr_err),
    .fetch_cnt     (w_fetch_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_ifid(input string tag, input logic [31:0] e_pc, input logic [31:0] e_inst,
                          input logic [31:0] e_pc4, input logic e_valid, input logic [31:0] e_cnt);
    chk({tag, ".pc"},      pc,        e_pc);
    chk({tag, ".im_addr"}, im_addr,   e_pc);
    chk({tag, ".inst"},    if_inst,   e_inst);
    chk({tag, ".pc4"},     if_pc4,    e_pc4);
    chk({tag, ".valid"},   {31'b0, if_valid}, {31'b0, e_valid});
    chk({tag, ".cnt"},     fetch_cnt, e_cnt);
  endtask

  initial begin
    for (int i = 0; i < 128; i++) mem[i] = 32'hA000_0000 | 32'(i);
    mem[0]  = 32'h2001_0001;
    mem[1]  = 32'h2002_0002;
    mem[2]  = 32'h2003_0003;
    mem[3]  = 32'h2004_0004;
    mem[4]  = 32'h2005_0005;
    mem[16] = 32'hAC00_0040;
    mem[17] = 32'hAC00_0044;

    reset = 1'b1; stall = 1'b0; flush = 1'b0;
    branch_taken = 1'b0; branch_target = 32'h0;

    // reset held for two edges
    tick(); tick();
    chk_ifid("reset", 32'h0, 32'h0, 32'h0, 1'b0, 32'd0);
    chk("reset.addr_err", {31'b0, addr_err}, 32'h0);
    chk("w_reset.pc", w_pc, 32'hFFFF_FFFC);
    chk("w_reset.im_addr", w_im_addr, 32'hFFFF_FFFC);
    chk("w_reset.valid", {31'b0, w_if_valid}, 32'h0);

    // sequential fetch
    reset = 1'b0;
    tick();
    chk_ifid("seq0", 32'h4, 32'h2001_0001, 32'h4, 1'b1, 32'd1);
    chk("w_wrap.pc", w_pc, 32'h0);
    chk("w_wrap.pc4", w_if_pc4, 32'h0);
    chk("w_wrap.inst", w_if_inst, 32'hA000_007F);
    chk("w_wrap.valid", {31'b0, w_if_valid}, 32'h1);
    chk("w_wrap.cnt", w_fetch_cnt, 32'd1);
    chk("w_wrap.addr_err", {31'b0, w_addr_err}, 32'h0);
    tick();
    chk_ifid("seq1", 32'h8, 32'h2002_0002, 32'h8, 1'b1, 32'd2);
    tick();
    chk_ifid("seq2", 32'hC, 32'h2003_0003, 32'hC, 1'b1, 32'd3);

    // stall three cycles
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_ifid("stall", 32'hC, 32'h2003_0003, 32'hC, 1'b1, 32'd3);
    end
    stall = 1'b0;
    tick();
    chk_ifid("resume", 32'h10, 32'h2004_0004, 32'h10, 1'b1, 32'd4);

    // delay slot: word at 0x10 still captured while pc redirects
    branch_taken = 1'b1; branch_target = 32'h40;
    tick();
    chk_ifid("dslot", 32'h40, 32'h2005_0005, 32'h14, 1'b1, 32'd5);
    branch_taken = 1'b0;
    tick();
    chk_ifid("dslot_tgt", 32'h44, 32'hAC00_0040, 32'h44, 1'b1, 32'd6);

    // redirect with flush, back to 0x10 then to 0x40
    branch_taken = 1'b1; flush = 1'b1; branch_target = 32'h10;
    tick();
    chk_ifid("flush_a", 32'h10, 32'h0, 32'h0, 1'b0, 32'd6);
    branch_target = 32'h40;
    tick();
    chk_ifid("flush_b", 32'h40, 32'h0, 32'h0, 1'b0, 32'd6);
    branch_taken = 1'b0; flush = 1'b0;
    tick();
    chk_ifid("flush_tgt", 32'h44, 32'hAC00_0040, 32'h44, 1'b1, 32'd7);

    // misaligned redirect during stall: pc aligned, IF/ID held, sticky error
    chk("pre_mis.addr_err", {31'b0, addr_err}, 32'h0);
    branch_taken = 1'b1; branch_target = 32'h42; stall = 1'b1;
    tick();
    chk_ifid("mis", 32'h40, 32'hAC00_0040, 32'h44, 1'b1, 32'd7);
    chk("mis.addr_err", {31'b0, addr_err}, 32'h1);
    branch_taken = 1'b0; stall = 1'b0;
    tick();
    chk_ifid("mis_after", 32'h44, 32'hAC00_0040, 32'h44, 1'b1, 32'd8);
    chk("sticky.addr_err", {31'b0, addr_err}, 32'h1);

    // stall+flush: PC holds, IF/ID cleared
    stall = 1'b1; flush = 1'b1;
    tick();
    chk_ifid("stall_flush", 32'h44, 32'h0, 32'h0, 1'b0, 32'd8);
    stall = 1'b0; flush = 1'b0;
    tick();
    chk_ifid("sf_resume", 32'h48, 32'hAC00_0044, 32'h48, 1'b1, 32'd9);

    // stall+branch+flush: redirect and clear
    stall = 1'b1; flush = 1'b1; branch_taken = 1'b1; branch_target = 32'h8;
    tick();
    chk_ifid("sbf", 32'h8, 32'h0, 32'h0, 1'b0, 32'd9);
    stall = 1'b0; flush = 1'b0; branch_taken = 1'b0;
    tick();
    chk_ifid("sbf_resume", 32'hC, 32'h2003_0003, 32'hC, 1'b1, 32'd10);

    // reset during an active stall
    stall = 1'b1;
    tick();
    chk_ifid("pre_rst", 32'hC, 32'h2003_0003, 32'hC, 1'b1, 32'd10);
    reset = 1'b1;
    tick();
    chk_ifid("mid_rst", 32'h0, 32'h0, 32'h0, 1'b0, 32'd0);
    chk("mid_rst.addr_err", {31'b0, addr_err}, 32'h0);
    chk("mid_rst.w_pc", w_pc, 32'hFFFF_FFFC);
    reset = 1'b0; stall = 1'b0;
    tick();
    chk_ifid("post_rst", 32'h4, 32'h2001_0001, 32'h4, 1'b1, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
